led_sweep_decoder: RTL and testbench

Monitors the 8-bit bouncing one-hot LED bus produced by the LED flasher and decodes it back into position, direction, sweep count and protocol faults. It sits beside the flasher on the same clock domain and is the receiving end of the LED sweep pattern. Its outputs feed status display and self-check logic.

---
 rtl/led_sweep_pkg.sv | 11 +
 rtl/led_onehot_enc.sv | 15 +
 rtl/led_sweep_decoder.sv | 130 +++++++++++++
 tb/tb_led_sweep_decoder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/led_sweep_pkg.sv
// led_sweep_pkg: shared states, fault codes and end-stop patterns for the LED sweep decoder.
package led_sweep_pkg;
  typedef enum logic [1:0] {SYNC, UP, DOWN, FAULT} sweep_state_t;
  typedef logic [1:0] fault_code_t;
  localparam fault_code_t FC_NONE   = 2'b00;
  localparam fault_code_t FC_ONEHOT = 2'b01;
  localparam fault_code_t FC_STEP   = 2'b10;
  localparam fault_code_t FC_STALL  = 2'b11;
  localparam logic [7:0] LED_BOTTOM = 8'h01;
  localparam logic [7:0] LED_TOP    = 8'h80;
endpackage

// File: rtl/led_onehot_enc.sv
// led_onehot_enc: combinational index/one-hot/zero classification of an 8-bit LED pattern.
module led_onehot_enc (
  input  logic [7:0] led,
  output logic [2:0] idx,
  output logic       is_onehot,
  output logic       is_zero
);
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (led[i]) idx = 3'(i);
  end
  assign is_zero   = led == 8'd0;
  assign is_onehot = !is_zero && ((led & (led - 8'd1)) == 8'd0);
endmodule

// File: rtl/led_sweep_decoder.sv
// led_sweep_decoder: decodes the bouncing one-hot LED bus into position, direction, sweep count and faults.
// Optional stall detection is enabled by defining LED_STALL_DET_EN.
module led_sweep_decoder
  import led_sweep_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int STALL_CYCLES = 100_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       led,
  output logic [2:0]       pos,
  output logic             dir,
  output logic             pos_valid,
  output logic             step,
  output logic             sweep_done,
  output logic [CNT_W-1:0] sweep_count,
  output logic             fault,
  output logic [1:0]       fault_code
);
  sweep_state_t     r_state, w_state_n;
  logic [7:0]       r_led_q;
  logic [2:0]       r_pos, w_pos_n;
  logic             r_dir, w_dir_n;
  logic             r_step, w_step_n;
  logic             r_done, w_done_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  fault_code_t      r_fc, w_fc_n;
  logic [2:0]       w_idx;
  logic             w_onehot, w_zero, w_change, w_bad_pat, w_up_ok, w_dn_ok;
  logic             w_lock_up, w_lock_dn, w_locked, w_stall;
  led_onehot_enc u_enc (
    .led       (led),
    .idx       (w_idx),
    .is_onehot (w_onehot),
    .is_zero   (w_zero)
  );
  assign w_change  = led != r_led_q;
  assign w_bad_pat = w_zero || !w_onehot;
  assign w_up_ok   = w_onehot && (w_idx == r_pos + 3'd1);
  assign w_dn_ok   = w_onehot && (w_idx == r_pos - 3'd1);
  assign w_lock_up = led == LED_BOTTOM;
  assign w_lock_dn = led == LED_TOP;
  assign w_locked  = (r_state == UP) || (r_state == DOWN);
`ifdef LED_STALL_DET_EN
  localparam int SW = $clog2(STALL_CYCLES);
  logic [SW-1:0] r_stall;
  // Restarts on any change or state entry so only a frozen locked pattern accumulates.
  always_ff @(posedge clk)
    if (!reset_n) r_stall <= '0;
    else r_stall <= (w_locked && !w_change && w_state_n == r_state) ? r_stall + 1'b1 : '0;
  assign w_stall = w_locked && (r_stall == SW'(STALL_CYCLES - 1));
`else
  assign w_stall = 1'b0;
`endif
  always_comb begin
    w_state_n = r_state;
    w_pos_n   = r_pos;
    w_dir_n   = r_dir;
    w_step_n  = 1'b0;
    w_done_n  = 1'b0;
    w_cnt_n   = r_cnt;
    w_fc_n    = r_fc;
    case (r_state)
      UP: begin
        if (w_change && w_up_ok) begin
          w_pos_n   = w_idx;
          w_step_n  = 1'b1;
          w_state_n = (w_idx == 3'd7) ? DOWN : UP;
          w_dir_n   = w_idx != 3'd7;
        end else if (w_change || w_stall) begin
          w_state_n = FAULT;
          w_fc_n    = !w_change ? FC_STALL : w_bad_pat ? FC_ONEHOT : FC_STEP;
        end
      end
      DOWN: begin
        if (w_change && w_dn_ok) begin
          w_pos_n   = w_idx;
          w_step_n  = 1'b1;
          w_state_n = (w_idx == 3'd0) ? UP : DOWN;
          w_dir_n   = w_idx == 3'd0;
          w_done_n  = w_idx == 3'd0;
          w_cnt_n   = (w_idx == 3'd0 && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
        end else if (w_change || w_stall) begin
          w_state_n = FAULT;
          w_fc_n    = !w_change ? FC_STALL : w_bad_pat ? FC_ONEHOT : FC_STEP;
        end
      end
      default: begin
        if (w_lock_up) begin
          w_state_n = UP;
          w_pos_n   = 3'd0;
          w_dir_n   = 1'b1;
        end else if (w_lock_dn) begin
          w_state_n = DOWN;
          w_pos_n   = 3'd7;
          w_dir_n   = 1'b0;
        end
      end
    endcase
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      r_state <= SYNC;
      r_led_q <= 8'd0;
      r_pos   <= 3'd0;
      r_dir   <= 1'b1;
      r_step  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_fc    <= FC_NONE;
    end else begin
      r_state <= w_state_n;
      r_led_q <= led;
      r_pos   <= w_pos_n;
      r_dir   <= w_dir_n;
      r_step  <= w_step_n;
      r_done  <= w_done_n;
      r_cnt   <= w_cnt_n;
      r_fc    <= w_fc_n;
    end
  assign pos         = r_pos;
  assign dir         = r_dir;
  assign pos_valid   = w_locked;
  assign step        = r_step;
  assign sweep_done  = r_done;
  assign sweep_count = r_cnt;
  assign fault       = r_state == FAULT;
  assign fault_code  = r_fc;
endmodule

// File: tb/tb_led_sweep_decoder.sv
// tb_led_sweep_decoder: directed self-checking bench for led_sweep_decoder (CNT_W=16 and CNT_W=2 instances).
module tb_led_sweep_decoder;
  logic        clk, reset_n;
  logic [7:0]  led;
  logic [2:0]  pos, pos2;
  logic        dir, pos_valid, step, sweep_done, fault;
  logic        dir2, pos_valid2, step2, sweep_done2, fault2;
  logic [15:0] sweep_count;
  logic [1:0]  sweep_count2, fault_code, fault_code2;
  int total = 0, bad = 0, n_step = 0, n_done = 0, n_done2 = 0;
  led_sweep_decoder #(.CNT_W(16), .STALL_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .led(led), .pos(pos), .dir(dir), .pos_valid(pos_valid),
    .step(step), .sweep_done(sweep_done), .sweep_count(sweep_count), .fault(fault), .fault_code(fault_code)
  );
  led_sweep_decoder #(.CNT_W(2), .STALL_CYCLES(10)) dut2 (
    .clk(clk), .reset_n(reset_n), .led(led), .pos(pos2), .dir(dir2), .pos_valid(pos_valid2),
    .step(step2), .sweep_done(sweep_done2), .sweep_count(sweep_count2), .fault(fault2), .fault_code(fault_code2)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    if (step) n_step++;
    if (sweep_done) n_done++;
    if (sweep_done2) n_done2++;
  endtask
  task automatic drive(input logic [7:0] p, input int n);
    led = p;
    repeat (n) tick();
  endtask
  task automatic bounce();
    for (int i = 1; i < 8; i++) drive(8'(1 << i), 1);
    for (int i = 6; i >= 0; i--) drive(8'(1 << i), 1);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset_n = 1'b0;
    led = 8'h00;
    tick();
    tick();
    chk("rst_pos", 32'(pos), 0);
    chk("rst_dir", 32'(dir), 1);
    chk("rst_valid", 32'(pos_valid), 0);
    chk("rst_step", 32'(step), 0);
    chk("rst_done", 32'(sweep_done), 0);
    chk("rst_cnt", 32'(sweep_count), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_fc", 32'(fault_code), 0);
    reset_n = 1'b1;
    drive(8'h00, 4);
    chk("sync_zero_valid", 32'(pos_valid), 0);
    n_step = 0;
    n_done = 0;
    led = 8'h01;
    tick();
    chk("lock_valid", 32'(pos_valid), 1);
    chk("lock_pos", 32'(pos), 0);
    chk("lock_step", 32'(step), 0);
    repeat (3) tick();
    for (int i = 1; i < 8; i++) begin
      led = 8'(1 << i);
      tick();
      chk("up_pos", 32'(pos), 32'(i));
      chk("up_step", 32'(step), 1);
      repeat (3) tick();
    end
    chk("top_dir", 32'(dir), 0);
    for (int i = 6; i >= 0; i--) begin
      led = 8'(1 << i);
      tick();
      chk("dn_pos", 32'(pos), 32'(i));
      chk("dn_done", 32'(sweep_done), (i == 0) ? 1 : 0);
      repeat (3) tick();
    end
    chk("sweep_steps", 32'(n_step), 14);
    chk("sweep_dones", 32'(n_done), 1);
    chk("sweep_cnt", 32'(sweep_count), 1);
    chk("sweep_dir", 32'(dir), 1);
    chk("sweep_fault", 32'(fault), 0);
    drive(8'h02, 2);
    drive(8'h04, 2);
    drive(8'h08, 2);
    drive(8'h20, 1);
    chk("skip_fault", 32'(fault), 1);
    chk("skip_fc", 32'(fault_code), 2);
    chk("skip_valid", 32'(pos_valid), 0);
    chk("skip_pos_frozen", 32'(pos), 3);
    drive(8'h01, 1);
    chk("relock_fault", 32'(fault), 0);
    chk("relock_pos", 32'(pos), 0);
    chk("relock_valid", 32'(pos_valid), 1);
    chk("relock_fc_hold", 32'(fault_code), 2);
    drive(8'h02, 1);
    drive(8'h04, 1);
    drive(8'h08, 1);
    drive(8'h10, 1);
    drive(8'h20, 1);
    chk("pos5", 32'(pos), 5);
    drive(8'h10, 1);
    chk("rev_fault", 32'(fault), 1);
    chk("rev_fc", 32'(fault_code), 2);
    drive(8'h01, 1);
    drive(8'h00, 1);
    chk("zero_fault", 32'(fault), 1);
    chk("zero_fc", 32'(fault_code), 1);
    drive(8'h80, 1);
    chk("top_lock_pos", 32'(pos), 7);
    chk("top_lock_dir", 32'(dir), 0);
    drive(8'h40, 1);
    drive(8'h80, 1);
    chk("dn_rev_fc", 32'(fault_code), 2);
    drive(8'h01, 1);
    drive(8'h03, 1);
    chk("multi_fc", 32'(fault_code), 1);
    chk("multi_fault", 32'(fault), 1);
    drive(8'h01, 1);
    bounce();
    chk("cnt2", 32'(sweep_count), 2);
    drive(8'h02, 1);
    drive(8'h04, 1);
    drive(8'h08, 1);
    drive(8'h10, 1);
    chk("mid_pos", 32'(pos), 4);
    reset_n = 1'b0;
    drive(8'h20, 1);
    chk("mrst_pos", 32'(pos), 0);
    chk("mrst_dir", 32'(dir), 1);
    chk("mrst_valid", 32'(pos_valid), 0);
    chk("mrst_step", 32'(step), 0);
    chk("mrst_cnt", 32'(sweep_count), 0);
    chk("mrst_fault", 32'(fault), 0);
    chk("mrst_fc", 32'(fault_code), 0);
    reset_n = 1'b1;
    drive(8'h80, 1);
    chk("post_rst_valid", 32'(pos_valid), 1);
    chk("post_rst_pos", 32'(pos), 7);
    chk("post_rst_dir", 32'(dir), 0);
    reset_n = 1'b0;
    drive(8'h00, 1);
    reset_n = 1'b1;
    n_done2 = 0;
    drive(8'h01, 1);
    repeat (5) bounce();
    chk("sat_cnt", 32'(sweep_count2), 3);
    chk("sat_dones", 32'(n_done2), 5);
    chk("wide_cnt", 32'(sweep_count), 5);
    drive(8'h02, 1);
    chk("stall_start_step", 32'(step), 1);
    repeat (9) tick();
    chk("stall_pre_fault", 32'(fault), 0);
    chk("stall_pre_valid", 32'(pos_valid), 1);
    tick();
`ifdef LED_STALL_DET_EN
    chk("stall_fault", 32'(fault), 1);
    chk("stall_fc", 32'(fault_code), 3);
`else
    chk("nostall_fault", 32'(fault), 0);
    repeat (20) tick();
    chk("nostall_fault_long", 32'(fault), 0);
    chk("nostall_fc", 32'(fault_code), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
